// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared geometry, pixel type and window-fetch FSM encoding for
//               the Conv datapath, its window feeder and output collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int IMG_W = 8;                // image width in pixels
  localparam int IMG_H = 8;                // image height in pixels
  localparam int K     = 3;                // kernel size (K x K window)
  localparam int DW    = 8;                // pixel width, signed Q1.7
  localparam int AW    = 6;                // image RAM address width
  localparam int OUT_W = IMG_W - K + 1;    // windows per output row
  localparam int OUT_N = 36;               // windows per frame

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_EMIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic signed [DW-1:0] pixel_t;

endpackage

`default_nettype wire

// File: rtl/conv_window_fetch_row_buffer.sv
// ============================================================================
// Module      : conv_row_buffer
// Description : K rows of IMG_W pixels. Supports a one-row upward shift,
//               single-pixel indexed writes and a combinational K x K window
//               read starting at a given column.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_row_buffer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              wr_en,
  input  logic [1:0]        wr_row,
  input  logic [2:0]        wr_col,
  input  logic [DW-1:0]     wr_data,
  input  logic [2:0]        rd_col,
  output logic [K*K*DW-1:0] window
);

  pixel_t r_buf [K][IMG_W];

  // Row storage: shift drops row 0 and moves the lower rows up; row K-1 keeps
  // its old contents until the refill writes land on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_buf[r][c] <= '0;
        end
      end
    end else if (shift) begin
      for (int r = 0; r < K - 1; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_buf[r][c] <= r_buf[r+1][c];
        end
      end
    end else if (wr_en) begin
      r_buf[wr_row][wr_col] <= pixel_t'(wr_data);
    end
  end

  // Window element k = r*K + c sits at bits [DW*k +: DW].
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      logic [2:0] w_col;
      assign w_col = rd_col + 3'(c);
      assign window[(r*K+c)*DW +: DW] = r_buf[r][w_col];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_window_fetch.sv
// ============================================================================
// Module      : conv_window_fetch
// Description : Reads an 8x8 image from the single-port image RAM, keeps three
//               rows in a row buffer and streams the 36 3x3 windows in raster
//               order over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_fetch
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd,
  output logic [AW-1:0]     ram_addr,
  input  logic [DW-1:0]     ram_dout,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [5:0]        win_idx,
  output logic              win_last
);

  state_t     r_state;
  logic [2:0] r_out_row;
  logic [2:0] r_out_col;
  logic       r_rd_d;     // RAM data valid this cycle
  logic [4:0] r_addr_d;   // address that produced the current RAM data

  logic       w_xfer;
  logic       w_row_end;
  logic       w_shift;
  logic       w_rd_last;
  logic       w_cap_last;
  logic [1:0] w_wr_row;
  logic [2:0] w_next_base;

  assign w_xfer    = win_valid && win_ready;
  assign w_row_end = w_xfer && (r_out_col == 3'(OUT_W - 1));
  assign w_shift   = (r_state == ST_EMIT) && w_row_end && (r_out_row != 3'(IMG_H - K));

  // FILL streams three whole rows; LOAD streams one row.
  assign w_rd_last  = (r_state == ST_FILL) ? (ram_addr == AW'(K*IMG_W - 1))
                                           : (ram_addr[2:0] == 3'(IMG_W - 1));
  assign w_cap_last = r_rd_d && ((r_state == ST_FILL) ? (r_addr_d == 5'(K*IMG_W - 1))
                                                      : (r_addr_d[2:0] == 3'(IMG_W - 1)));

  // During FILL the row comes from the address; refills always land in the bottom row.
  assign w_wr_row    = (r_state == ST_FILL) ? r_addr_d[4:3] : 2'(K - 1);
  // Bottom row of the next band is image row (out_row + 1) + 2.
  assign w_next_base = r_out_row + 3'd3;

  assign win_last = win_valid && (win_idx == 6'(OUT_N - 1));

  conv_row_buffer u_row_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (w_shift),
    .wr_en   (r_rd_d),
    .wr_row  (w_wr_row),
    .wr_col  (r_addr_d[2:0]),
    .wr_data (ram_dout),
    .rd_col  (r_out_col),
    .window  (win_data)
  );

  // Frame sequencer: read generation, window handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_out_row <= '0;
      r_out_col <= '0;
      r_rd_d    <= 1'b0;
      r_addr_d  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      win_valid <= 1'b0;
      win_idx   <= '0;
    end else begin
      r_rd_d   <= ram_rd;
      r_addr_d <= ram_addr[4:0];
      done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_FILL;
            busy      <= 1'b1;
            ram_rd    <= 1'b1;
            ram_addr  <= '0;
            win_idx   <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
          end
        end
        ST_FILL, ST_LOAD: begin
          if (ram_rd) begin
            if (w_rd_last) begin
              ram_rd   <= 1'b0;
              ram_addr <= '0;
            end else begin
              ram_addr <= ram_addr + AW'(1);
            end
          end
          if (w_cap_last) begin
            r_state   <= ST_EMIT;
            win_valid <= 1'b1;
            r_out_col <= '0;
          end
        end
        ST_EMIT: begin
          if (w_xfer) begin
            if (w_row_end) begin
              win_valid <= 1'b0;
              r_out_col <= '0;
              if (r_out_row == 3'(IMG_H - K)) begin
                r_state   <= ST_DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
                win_idx   <= '0;
                r_out_row <= '0;
              end else begin
                r_state   <= ST_LOAD;
                r_out_row <= r_out_row + 3'd1;
                ram_rd    <= 1'b1;
                ram_addr  <= {w_next_base, 3'b000};
                win_idx   <= win_idx + 6'd1;
              end
            end else begin
              r_out_col <= r_out_col + 3'd1;
              win_idx   <= win_idx + 6'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
// ============================================================================
// Module      : tb_conv_window_fetch
// Description : Directed self-checking bench for conv_window_fetch with an
//               image RAM model and a reference window model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_fetch;
  import conv_pkg::*;

  typedef struct {
    bit bp;            // pseudo-random win_ready
    int extra_start;   // cycle of an extra start pulse, -1 for none
    bit signed_img;    // ramp with signed corner values
    bit b2b;           // start the cycle right after the previous done
    int exp_first;     // first win_valid cycle, -1 = not checked
    int exp_last;      // last transfer cycle
    int exp_done;      // done cycle
  } scen_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              win_ready = 1'b0;
  logic              busy, done, ram_rd, win_valid, win_last;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_dout = '0;
  logic [K*K*DW-1:0] win_data;
  logic [5:0]        win_idx;

  int total = 0;
  int bad = 0;
  logic [7:0]  mem [64];
  logic [71:0] got_win [36];
  scen_t       tbl [5];

  conv_window_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_idx   (win_idx),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  // Image RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_img(input bit signed_img);
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    if (signed_img) begin
      mem[0]  = 8'h80;
      mem[9]  = 8'h7F;
      mem[18] = 8'hFF;
    end
  endtask

  function automatic logic [71:0] exp_win(input int i);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = mem[((i/6 + r)*8 + (i%6) + c) % 64];
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 72'(busy), 72'(0));
      chk("idle_done", 72'(done), 72'(0));
      chk("idle_rd", 72'(ram_rd), 72'(0));
      chk("idle_addr", 72'(ram_addr), 72'(0));
      chk("idle_valid", 72'(win_valid), 72'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input scen_t s);
    int n_xfer, n_rd, first_valid, last_xfer, done_at;
    logic pv, pr;
    logic [71:0] pd;
    logic [5:0] pi;
    n_xfer = 0; n_rd = 0; first_valid = -1; last_xfer = -1; done_at = -1;
    pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
    for (int rel = 0; rel < 3000 && done_at < 0; rel++) begin
      start = (rel == 0) || (rel == s.extra_start);
      win_ready = s.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (ram_rd) begin
        if (n_rd == 0) chk("first_read_cycle", 72'(rel), 72'(1));
        chk("read_addr", 72'(ram_addr), 72'(n_rd));
        n_rd++;
      end
      if (done) done_at = rel;
      chk("busy", 72'(busy), 72'(rel >= 1 && !done));
      if (pv && !pr) begin
        chk("stall_valid", 72'(win_valid), 72'(1));
        chk("stall_data", win_data, pd);
        chk("stall_idx", 72'(win_idx), 72'(pi));
      end
      if (win_valid && first_valid < 0) first_valid = rel;
      if (win_valid && win_ready) begin
        chk("win_idx", 72'(win_idx), 72'(n_xfer));
        chk("win_data", win_data, (n_xfer < 36) ? exp_win(n_xfer) : '1);
        chk("win_last", 72'(win_last), 72'(n_xfer == 35));
        if (n_xfer < 36) got_win[n_xfer] = win_data;
        n_xfer++;
        last_xfer = rel;
      end
      pv = win_valid; pr = win_ready; pd = win_data; pi = win_idx;
      @(posedge clk); #1;
    end
    start = 1'b0;
    win_ready = 1'b0;
    if (done_at < 0) begin
      total++; bad++;
      $display("FAIL frame_timeout: got no done expected done within 3000 cycles");
    end
    chk("xfer_count", 72'(n_xfer), 72'(36));
    chk("read_count", 72'(n_rd), 72'(64));
    if (s.exp_first >= 0) begin
      chk("first_valid_cycle", 72'(first_valid), 72'(s.exp_first));
      chk("last_xfer_cycle", 72'(last_xfer), 72'(s.exp_last));
      chk("done_cycle", 72'(done_at), 72'(s.exp_done));
    end
  endtask

  initial begin
    tbl[0] = '{bp: 1'b0, extra_start: -1, signed_img: 1'b0, b2b: 1'b0, exp_first: 26, exp_last: 106, exp_done: 107};
    tbl[1] = '{bp: 1'b1, extra_start: -1, signed_img: 1'b0, b2b: 1'b0, exp_first: -1, exp_last: -1, exp_done: -1};
    tbl[2] = '{bp: 1'b0, extra_start: -1, signed_img: 1'b1, b2b: 1'b0, exp_first: 26, exp_last: 106, exp_done: 107};
    tbl[3] = '{bp: 1'b0, extra_start: 50, signed_img: 1'b0, b2b: 1'b0, exp_first: 26, exp_last: 106, exp_done: 107};
    tbl[4] = '{bp: 1'b0, extra_start: -1, signed_img: 1'b0, b2b: 1'b1, exp_first: 26, exp_last: 106, exp_done: 107};
    set_img(1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_rd", 72'(ram_rd), 72'(0));
    chk("rst_addr", 72'(ram_addr), 72'(0));
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_last", 72'(win_last), 72'(0));
    chk("rst_idx", 72'(win_idx), 72'(0));
    chk("rst_data", win_data, 72'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      set_img(tbl[i].signed_img);
      if (!tbl[i].b2b) idle(3);
      run_frame(tbl[i]);
      if (i == 0) begin
        chk("ramp_win0", got_win[0], 72'h12_11_10_0A_09_08_02_01_00);
        chk("ramp_win35", got_win[35], 72'h3F_3E_3D_37_36_35_2F_2E_2D);
      end
      if (i == 2) begin
        chk("signed_b0", 72'(got_win[0][7:0]), 72'(8'h80));
        chk("signed_b4", 72'(got_win[0][39:32]), 72'(8'h7F));
        chk("signed_b8", 72'(got_win[0][71:64]), 72'(8'hFF));
      end
    end

    // Asynchronous reset in the middle of a frame, then a clean frame.
    set_img(1'b0);
    idle(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 72'(busy), 72'(0));
    chk("abort_done", 72'(done), 72'(0));
    chk("abort_rd", 72'(ram_rd), 72'(0));
    chk("abort_addr", 72'(ram_addr), 72'(0));
    chk("abort_valid", 72'(win_valid), 72'(0));
    chk("abort_idx", 72'(win_idx), 72'(0));
    chk("abort_data", win_data, 72'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_hold_done", 72'(done), 72'(0));
      chk("abort_hold_busy", 72'(busy), 72'(0));
      chk("abort_hold_valid", 72'(win_valid), 72'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
    run_frame(tbl[0]);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Upstream feeder for the Conv datapath.
- Reads an 8x8 signed 8-bit image from the single-port image RAM (64 x 8, 6-bit address, 1-cycle read latency), buffers 3 image rows, and emits the 36 3x3 windows in raster order over a valid/ready handshake.
- Replaces testbench-driven streaming, so Conv only sees complete windows.

Parameters:
IMG_W, 8, image width in pixels
IMG_H, 8, image height in pixels
K, 3, kernel size (window is K x K)
DW, 8, pixel width (signed Q1.7)
AW, 6, RAM address width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after the last window transfers
ram_rd  out  1  read strobe; RAM wr held 0 by this block
ram_addr  out  AW  read address
ram_dout  in  DW  signed read data, valid the cycle after ram_rd
win_valid  out  1  window presented
win_ready  in  1  consumer accepts window
win_data  out  K*K*DW  window; element k=r*3+c at bits [8k+7:8k], r = window row, c = window column
win_idx  out  6  window index 0..35 (out_row*6+out_col)
win_last  out  1  high with window 35

Behaviour:
- Reset state:
  - busy, done, ram_rd, win_valid and win_last = 0; ram_addr, win_idx and win_data = 0.
  - Row buffers are cleared; FSM goes to IDLE.
- Reset is asynchronous: asserting rst_n low mid-frame aborts the frame immediately; no done pulse.
- FSM states: IDLE, FILL, EMIT, LOAD, DONE.
- IDLE:
  - start sampled high -> FILL; busy = 1 from the next cycle.
  - start is ignored whenever busy = 1.
- FILL:
  - ram_rd = 1 for 24 consecutive cycles with ram_addr = 0..23.
  - Data captured one cycle later into buf[addr/8][addr%8].
  - After the capture of addr 23 -> EMIT, out_row = 0, out_col = 0.
- EMIT:
  - win_valid = 1; win_data = buf[0..2][out_col..out_col+2]; win_idx = out_row*6 + out_col.
  - Transfer occurs on a cycle with win_valid && win_ready.
  - While win_ready = 0, win_data and win_idx are held stable and win_valid stays high.
  - On transfer, out_col increments. Back-to-back transfers are allowed: one window per cycle.
  - Transfer with out_col = 5: if out_row = 5 -> DONE; otherwise -> LOAD.
- LOAD:
  - On entry: buf[0] <- buf[1], buf[1] <- buf[2], out_row increments.
  - Then 8 reads of ram_addr = (out_row+2)*8 + 0..7, captured into buf[2].
  - After the last capture -> EMIT with out_col = 0.
  - win_valid = 0 throughout LOAD.
- DONE: done = 1 for one cycle, busy = 0 in that same cycle, -> IDLE.
- Latency (start sampled at cycle 0, win_ready tied high):
  - First read at cycle 1; first win_valid at cycle 26.
  - After each row-end transfer at cycle t, the next win_valid is at t+10.
  - Last transfer at cycle 106; done at cycle 107.
- Arithmetic:
  - Pixels are passed bit-exact (signed, no scaling).
  - Address arithmetic is modulo 2^AW; the sequence never exceeds 63.
- ram_addr returns to 0 and ram_rd = 0 whenever no read is issued.
- win_last = win_valid && win_idx == 35.

Decomposition:
- Package conv_pkg: IMG_W, IMG_H, K, DW, AW, OUT_W = IMG_W-K+1, OUT_N = 36, the FSM state enum, and a pixel_t signed [DW-1:0] typedef.
- Shared with Conv and the output collector.
- One sub-module, conv_row_buffer:
  - K x IMG_W register array with row-shift, indexed write, and a K x K column-window read port.
  - The FSM, address generation and handshake stay in conv_window_fetch.

Test Plan:
- Ramp image (mem[a] = a), win_ready = 1, start at cycle 0:
  - window 0 = {0,1,2,8,9,10,16,17,18} at cycle 26;
  - window 35 = {45,46,47,53,54,55,61,62,63} with win_last;
  - done at cycle 107; exactly 36 transfers.
- Backpressure: toggle win_ready pseudo-randomly on the ramp image -> all 36 windows in order with correct data; win_data stable during every stalled cycle; no window lost or duplicated.
- Signed data: mem[0] = -128, mem[9] = 127, mem[18] = -1 -> window 0 bytes 0/4/8 = 8'h80/8'h7F/8'hFF.
- start pulsed at cycle 50 during a frame -> ignored: single done, still 36 windows, read address sequence unchanged.
- rst_n low at cycle 60 for 2 cycles:
  - all outputs 0 immediately, no done;
  - a new start after release yields a full correct 36-window frame.
- Back-to-back frames: start the cycle after done -> second frame identical to the first, first read 1 cycle after start.
